// File: rtl/gray_bin_conv_pipe_pkg.sv
// Shared constants and reference conversions for the pipelined Gray<->binary converter.
// Optional round-trip checker is enabled with the GRAY_CONV_CHECK_EN macro.
package gray_conv_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Width of each Gray->binary slice; the final slice takes whatever is left.
    function automatic int slice_w(input int w, input int stages);
        return (w + stages - 1) / stages;
    endfunction

    function automatic logic [31:0] b2g(input logic [31:0] d);
        return d ^ (d >> 1);
    endfunction

    // Operands are zero-extended, so the unused upper bits resolve to zero.
    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_bin_conv_pipe_if.sv
// Handshake bundle between a word source, the converter and a result consumer.
// Optional round-trip checker (GRAY_CONV_CHECK_EN) does not touch this bundle.
interface gray_bin_conv_pipe_if #(
    parameter int W = 4
);

    // valid/ready: a word moves only on a clock edge where valid && ready; valid
    // must not depend on ready, and an offered word stays put until it moves.
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );

endinterface

// File: rtl/gray_bin_conv_pipe_stage.sv
// One converter pipeline stage: registers valid/mode/data and resolves its Gray->binary slice.
// With GRAY_CONV_CHECK_EN the original input word rides alongside the data.
module gray_conv_stage
    import gray_conv_pkg::*;
#(
    parameter int W      = 4,
    parameter int STAGES = 2,
    parameter int SLICE  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic         in_mode,
    input  logic [W-1:0] in_data,
`ifdef GRAY_CONV_CHECK_EN
    input  logic [W-1:0] in_orig,
    output logic [W-1:0] out_orig,
`endif
    output logic         out_valid,
    output logic         out_mode,
    output logic [W-1:0] out_data
);

    localparam int SW = slice_w(W, STAGES);
    localparam int HI = W - 1 - SLICE * SW;
    localparam int LO = (HI - SW + 1 > 0) ? (HI - SW + 1) : 0;

    logic [W-1:0] res;

    // Bits above this slice are already binary; the top bit of the slice chains off them.
    always_comb begin
        res = in_data;
        if (in_mode == MODE_B2G) begin
            if (SLICE == 0) res = in_data ^ (in_data >> 1);
        end else begin
            for (int i = W - 2; i >= 0; i--) begin
                if (i >= LO && i <= HI) res[i] = res[i+1] ^ in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_data  <= '0;
`ifdef GRAY_CONV_CHECK_EN
            out_orig  <= '0;
`endif
        end else if (en) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_data  <= res;
`ifdef GRAY_CONV_CHECK_EN
            out_orig  <= in_orig;
`endif
        end
    end

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined Gray<->binary converter top: STAGES stage instances under one global stall.
// Define GRAY_CONV_CHECK_EN to add the sticky round-trip checker output chk_err.
module gray_bin_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    gray_bin_conv_pipe_if.slave bus
`ifdef GRAY_CONV_CHECK_EN
    ,
    output logic                chk_err
`endif
);

    logic         valid [STAGES+1];
    logic         mode  [STAGES+1];
    logic [W-1:0] data  [STAGES+1];
    logic         stall;
    logic         advance;

    // Bubbles are never squeezed out: the whole pipe moves or holds as one.
    assign stall   = valid[STAGES] && !bus.out_ready;
    assign advance = !stall;

    assign valid[0] = bus.in_valid;
    assign mode[0]  = bus.in_mode;
    assign data[0]  = bus.in_data;

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid[STAGES];
    assign bus.out_mode  = mode[STAGES];
    assign bus.out_data  = data[STAGES];

`ifdef GRAY_CONV_CHECK_EN
    logic [W-1:0] orig [STAGES+1];
    logic [W-1:0] inverse;

    assign orig[0] = bus.in_data;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        gray_conv_stage #(
            .W      (W),
            .STAGES (STAGES),
            .SLICE  (s)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (valid[s]),
            .in_mode   (mode[s]),
            .in_data   (data[s]),
`ifdef GRAY_CONV_CHECK_EN
            .in_orig   (orig[s]),
            .out_orig  (orig[s+1]),
`endif
            .out_valid (valid[s+1]),
            .out_mode  (mode[s+1]),
            .out_data  (data[s+1])
        );
    end

`ifdef GRAY_CONV_CHECK_EN
    // Undoing the conversion must give back the word that entered.
    always_comb begin
        if (mode[STAGES] == MODE_B2G) inverse = W'(g2b(32'(data[STAGES])));
        else                          inverse = W'(b2g(32'(data[STAGES])));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (valid[STAGES] && bus.out_ready && inverse != orig[STAGES]) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Bench for gray_bin_conv_pipe: W=4/STAGES=2 and W=7/STAGES=3 instances against a prefix-XOR model.
// Also checks chk_err when built with GRAY_CONV_CHECK_EN.
module tb_gray_bin_conv_pipe;
    import gray_conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    logic [4:0] exp_qa[$];
    logic [7:0] exp_qb[$];

    always #5 clk = ~clk;

    gray_bin_conv_pipe_if #(.W(4)) bus_a ();
    gray_bin_conv_pipe_if #(.W(7)) bus_b ();

`ifdef GRAY_CONV_CHECK_EN
    logic chk_a, chk_b;
`endif

    gray_bin_conv_pipe #(.W(4), .STAGES(2)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_a)
`ifdef GRAY_CONV_CHECK_EN
        ,
        .chk_err (chk_a)
`endif
    );

    gray_bin_conv_pipe #(.W(7), .STAGES(3)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_b)
`ifdef GRAY_CONV_CHECK_EN
        ,
        .chk_err (chk_b)
`endif
    );

    // Binary bit i is the parity of all Gray bits at or above i: XOR of every right shift.
    function automatic logic [6:0] ref_conv(input logic mo, input logic [6:0] d, input int w);
        logic [6:0] r;
        r = '0;
        if (mo) r = d ^ (d >> 1);
        else for (int k = 0; k < w; k++) r = r ^ (d >> k);
        return r;
    endfunction

    task automatic cycle_a(input logic v, input logic mo, input logic [3:0] di, input logic ordy,
                           output logic ov, output logic om, output logic [3:0] od, output logic ir);
        bus_a.in_valid  = v;
        bus_a.in_mode   = mo;
        bus_a.in_data   = di;
        bus_a.out_ready = ordy;
        #1;
        ov = bus_a.out_valid;
        om = bus_a.out_mode;
        od = bus_a.out_data;
        ir = bus_a.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_b(input logic v, input logic mo, input logic [6:0] di, input logic ordy,
                           output logic ov, output logic om, output logic [6:0] od, output logic ir);
        bus_b.in_valid  = v;
        bus_b.in_mode   = mo;
        bus_b.in_data   = di;
        bus_b.out_ready = ordy;
        #1;
        ov = bus_b.out_valid;
        om = bus_b.out_mode;
        od = bus_b.out_data;
        ir = bus_b.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.in_valid = 1'b0; bus_a.in_mode = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_mode = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 4'd0 || bus_a.out_mode !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_a: got v=%b d=%h m=%b rdy=%b, want v=0 d=0 m=0 rdy=1",
                     bus_a.out_valid, bus_a.out_data, bus_a.out_mode, bus_a.in_ready);
        end
        checks++;
        if (bus_b.out_valid !== 1'b0 || bus_b.out_data !== 7'd0 || bus_b.out_mode !== 1'b0 || bus_b.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_b: got v=%b d=%h m=%b rdy=%b, want v=0 d=0 m=0 rdy=1",
                     bus_b.out_valid, bus_b.out_data, bus_b.out_mode, bus_b.in_ready);
        end
`ifdef GRAY_CONV_CHECK_EN
        checks++;
        if (chk_a !== 1'b0 || chk_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_chk_err: got a=%b b=%b, want 0 0", chk_a, chk_b);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        logic ov, om, ir;
        logic [3:0] od, got_d;
        logic got_m;
        int first = -1;
        for (int c = 0; c < 6; c++) begin
            cycle_a(c == 0, MODE_G2B, 4'b1101, 1'b1, ov, om, od, ir);
            if (ov && first < 0) begin
                first = c; got_d = od; got_m = om;
            end
        end
        checks++;
        if (first != 2) begin
            fails++;
            $display("FAIL latency_g2b: output seen at cycle %0d, want cycle 2", first);
        end else begin
            checks++;
            if (got_d !== 4'b1001 || got_m !== MODE_G2B) begin
                fails++;
                $display("FAIL g2b_1101: got d=%b m=%b, want d=1001 m=0", got_d, got_m);
            end
        end
    endtask

    task automatic test_b2g_mixed();
        logic ov, om, ir, mo;
        logic [3:0] od, di;
        logic [4:0] exp;
        logic [3:0] words [12];
        int n_in = 0, n_out = 0;
        words[0] = 4'b1001;
        for (int i = 1; i < 12; i++) words[i] = 4'($urandom_range(0, 15));
        exp_qa.delete();
        for (int c = 0; c < 40 && n_out < 12; c++) begin
            mo = (n_in % 2 == 0) ? MODE_B2G : MODE_G2B;
            di = words[n_in % 12];
            cycle_a(n_in < 12, mo, di, 1'b1, ov, om, od, ir);
            if (ov) begin
                checks++;
                if (exp_qa.size() == 0) begin
                    fails++;
                    $display("FAIL mixed_extra: unexpected word d=%b m=%b", od, om);
                end else begin
                    exp = exp_qa.pop_front();
                    if ({om, od} !== exp) begin
                        fails++;
                        $display("FAIL mixed_word%0d: got m=%b d=%b, want m=%b d=%b", n_out, om, od, exp[4], exp[3:0]);
                    end
                end
                if (n_out == 0) begin
                    checks++;
                    if (od !== 4'b1101 || om !== MODE_B2G) begin
                        fails++;
                        $display("FAIL b2g_1001: got d=%b m=%b, want d=1101 m=1", od, om);
                    end
                end
                n_out++;
            end
            if (n_in < 12 && ir) begin
                exp_qa.push_back({mo, 4'(ref_conv(mo, 7'(di), 4))});
                n_in++;
            end
        end
        checks++;
        if (n_out != 12) begin
            fails++;
            $display("FAIL mixed_count: got %0d words, want 12", n_out);
        end
    endtask

    task automatic test_sweep();
        logic ov, om, ir;
        logic [3:0] od, g;
        int n_in = 0, n_out = 0;
        for (int c = 0; c < 24 && n_out < 16; c++) begin
            g = 4'(n_in ^ (n_in >> 1));
            cycle_a(n_in < 16, MODE_G2B, g, 1'b1, ov, om, od, ir);
            if (ov) begin
                checks++;
                if (od !== 4'(n_out) || c != n_out + 2) begin
                    fails++;
                    $display("FAIL sweep_%0d: got %0d at cycle %0d, want %0d at cycle %0d", n_out, od, c, n_out, n_out + 2);
                end
                n_out++;
            end
            if (n_in < 16 && ir) n_in++;
        end
        checks++;
        if (n_out != 16) begin
            fails++;
            $display("FAIL sweep_count: got %0d words, want 16", n_out);
        end
    endtask

    task automatic test_backpressure();
        logic ov, om, ir, ordy, mo;
        logic [3:0] od, held, di;
        logic [4:0] exp;
        int n_in = 0, n_out = 0;
        exp_qa.delete();
        held = '0;
        for (int c = 0; c < 40 && n_out < 12; c++) begin
            ordy = !(c >= 3 && c < 8);
            mo = 1'($urandom_range(0, 1));
            di = 4'($urandom_range(0, 15));
            cycle_a(n_in < 12, mo, di, ordy, ov, om, od, ir);
            if (c == 3) held = od;
            if (!ordy) begin
                checks++;
                if (ir !== 1'b0 || ov !== 1'b1 || od !== held) begin
                    fails++;
                    $display("FAIL stall_c%0d: got rdy=%b v=%b d=%b, want rdy=0 v=1 d=%b", c, ir, ov, od, held);
                end
            end
            if (ov && ordy) begin
                checks++;
                if (exp_qa.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: unexpected word d=%b", od);
                end else begin
                    exp = exp_qa.pop_front();
                    if ({om, od} !== exp) begin
                        fails++;
                        $display("FAIL bp_word%0d: got m=%b d=%b, want m=%b d=%b", n_out, om, od, exp[4], exp[3:0]);
                    end
                end
                n_out++;
            end
            if (n_in < 12 && ir) begin
                exp_qa.push_back({mo, 4'(ref_conv(mo, 7'(di), 4))});
                n_in++;
            end
        end
        checks++;
        if (n_out != 12 || exp_qa.size() != 0) begin
            fails++;
            $display("FAIL bp_count: got %0d words (%0d left), want 12 (0 left)", n_out, exp_qa.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic ov, om, ir;
        logic [3:0] od, exp_d;
        int n_out = 0, first = -1;
        cycle_a(1'b1, MODE_G2B, 4'b0110, 1'b1, ov, om, od, ir);
        cycle_a(1'b1, MODE_B2G, 4'b0011, 1'b1, ov, om, od, ir);
        rst = 1'b1;
        cycle_a(1'b1, MODE_B2G, 4'b1111, 1'b1, ov, om, od, ir);
        rst = 1'b0;
        exp_d = 4'(ref_conv(MODE_G2B, 7'b0001011, 4));
        for (int c = 0; c < 6; c++) begin
            cycle_a(c == 0, MODE_G2B, 4'b1011, 1'b1, ov, om, od, ir);
            if (c == 0) begin
                checks++;
                if (ov !== 1'b0 || od !== 4'd0 || om !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_flush: got v=%b d=%b m=%b, want v=0 d=0 m=0", ov, od, om);
                end
            end
            if (ov) begin
                n_out++;
                if (first < 0) begin
                    first = c;
                    checks++;
                    if (od !== exp_d) begin
                        fails++;
                        $display("FAIL rst_next_word: got %b, want %b", od, exp_d);
                    end
                end
            end
        end
        checks++;
        if (first != 2 || n_out != 1) begin
            fails++;
            $display("FAIL rst_latency: first at cycle %0d with %0d words, want cycle 2 with 1 word", first, n_out);
        end
    endtask

    task automatic test_uneven_random();
        logic ov, om, ir, v, mo, ordy, p_stall, p_mode;
        logic [6:0] od, di, p_data;
        logic [7:0] exp;
        int n_in = 0, n_out = 0, cyc = 0, first = -1;
        for (int c = 0; c < 8; c++) begin
            cycle_b(c == 0, MODE_G2B, 7'b1010011, 1'b1, ov, om, od, ir);
            if (ov && first < 0) begin
                first = c;
                checks++;
                if (od !== ref_conv(MODE_G2B, 7'b1010011, 7)) begin
                    fails++;
                    $display("FAIL w7_g2b: got %b, want %b", od, ref_conv(MODE_G2B, 7'b1010011, 7));
                end
            end
        end
        checks++;
        if (first != 3) begin
            fails++;
            $display("FAIL w7_latency: output at cycle %0d, want cycle 3", first);
        end
        exp_qb.delete();
        p_stall = 1'b0; p_mode = 1'b0; p_data = '0;
        while (n_out < 1000 && cyc < 6000) begin
            v    = (n_in < 1000) && ($urandom_range(0, 9) < 8);
            mo   = 1'($urandom_range(0, 1));
            di   = 7'($urandom_range(0, 127));
            ordy = ($urandom_range(0, 3) != 0);
            cycle_b(v, mo, di, ordy, ov, om, od, ir);
            checks++;
            if (ir !== !(ov && !ordy)) begin
                fails++;
                $display("FAIL w7_in_ready_c%0d: got %b, want %b", cyc, ir, !(ov && !ordy));
            end
            if (p_stall) begin
                checks++;
                if (ov !== 1'b1 || od !== p_data || om !== p_mode) begin
                    fails++;
                    $display("FAIL w7_hold_c%0d: got v=%b m=%b d=%b, want v=1 m=%b d=%b", cyc, ov, om, od, p_mode, p_data);
                end
            end
            if (ov && ordy) begin
                checks++;
                if (exp_qb.size() == 0) begin
                    fails++;
                    $display("FAIL w7_extra: unexpected word d=%b", od);
                end else begin
                    exp = exp_qb.pop_front();
                    if ({om, od} !== exp) begin
                        fails++;
                        $display("FAIL w7_word%0d: got m=%b d=%b, want m=%b d=%b", n_out, om, od, exp[7], exp[6:0]);
                    end
                end
                n_out++;
            end
            if (v && ir) begin
                exp_qb.push_back({mo, ref_conv(mo, di, 7)});
                n_in++;
            end
            p_stall = ov && !ordy;
            p_data  = od;
            p_mode  = om;
            cyc++;
        end
        checks++;
        if (n_out != 1000 || exp_qb.size() != 0) begin
            fails++;
            $display("FAIL w7_count: got %0d words (%0d left) in %0d cycles, want 1000 (0 left)", n_out, exp_qb.size(), cyc);
        end
`ifdef GRAY_CONV_CHECK_EN
        checks++;
        if (chk_a !== 1'b0 || chk_b !== 1'b0) begin
            fails++;
            $display("FAIL chk_err_clean: got a=%b b=%b, want 0 0", chk_a, chk_b);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_b2g_mixed();
        test_sweep();
        test_backpressure();
        test_reset_midstream();
        test_uneven_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
